ysyx_rob: RTL and testbench
===========================

Name: ysyx_rob

Overview:
- Reorder buffer directly downstream of the execute/reservation-station stage.
- Allocates in-order tags at dispatch and captures out-of-order execute writebacks by tag.
- Retires one entry per cycle in program order to the register file and CSR/trap logic.
- Raises a pipeline flush on a mispredicted or trapping retire, and answers operand-value queries for dispatch.

Parameters:
- ROB_SIZE, 8: number of entries; power of two, at least 2.
- XLEN, 32: datapath width.
- TAG_W, $clog2(ROB_SIZE)+1: tag width. Tag = entry index + 1; tag 0 means "no dependency".

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- dis_valid  in  1  dispatch request
- dis_ready  out  1  entry available
- dis_pc  in  XLEN  instruction pc
- dis_inst  in  32  instruction word
- dis_rd  in  5  destination register; 0 = no write
- dis_pnpc  in  XLEN  predicted next pc
- dis_tag  out  TAG_W  tag to be allocated (tail index + 1)
- qa_tag  in  TAG_W  operand query A
- qa_ready  out  1  query A value available
- qa_value  out  XLEN  query A value
- qb_tag, qb_ready, qb_value: same as query A, port B
- wb_valid  in  1  execute result valid
- wb_dest  in  TAG_W  tag being written back
- wb_result  in  XLEN  rd value
- wb_npc  in  XLEN  resolved next pc
- wb_trap  in  1  exception
- wb_cause  in  XLEN  trap cause
- wb_tval  in  XLEN  trap value
- cm_valid  out  1  retiring this cycle
- cm_tag  out  TAG_W  retiring tag
- cm_rd  out  5  retiring destination register
- cm_result  out  XLEN  retiring value
- cm_pc  out  XLEN  retiring pc
- cm_inst  out  32  retiring instruction
- cm_trap, cm_cause, cm_tval  out  1/XLEN/XLEN  trap information
- flush_pipeline  out  1  flush all younger state
- flush_pc  out  XLEN  redirect target

Behaviour:
- State:
  - head and tail pointers, $clog2(ROB_SIZE) bits each, wrapping modulo ROB_SIZE.
  - count, 0..ROB_SIZE.
  - Per entry: busy, done, rd, pc, inst, pnpc, result, npc, trap, cause, tval.
- Reset: head = tail = count = 0; all busy/done = 0.
  - Outputs after reset: dis_ready = 1, dis_tag = 1, cm_valid = 0, flush_pipeline = 0, qa_ready = qb_ready = 0, all data outputs 0.
- Dispatch:
  - dis_ready = (count != ROB_SIZE). A full ROB is not relieved by a same-cycle retire; no bypass.
  - On dis_valid & dis_ready at a clock edge: entry[tail] gets busy = 1, done = 0 and the dispatch fields; tail advances.
  - dis_tag is combinational from tail.
- Writeback:
  - On wb_valid with wb_dest != 0 and entry[wb_dest-1] busy & !done: store result, npc, trap, cause, tval; set done = 1.
  - Writeback to a non-busy or already-done entry, or to tag 0, is ignored.
- Retire:
  - cm_valid = busy[head] & done[head]; combinational. An entry written back at edge N can retire in the cycle after edge N, i.e. minimum one cycle from writeback to retire.
  - When cm_valid, all cm_* outputs reflect entry[head]. At the edge: clear busy/done of head, advance head.
  - cm_rd is forced to 0 when cm_trap = 1.
- Flush:
  - flush_pipeline = cm_valid & (trap[head] | npc[head] != pnpc[head]); combinational.
  - flush_pc = npc[head], which for a trap is the trap vector supplied by the execute stage.
  - On a flush edge, after the retire: all busy/done cleared, head = tail = count = 0, and a same-cycle dispatch is dropped.
- Count: +1 on dispatch only, -1 on retire only, unchanged when both occur. Wrap-around of head/tail is modular.
- Query (both ports identical):
  - If wb_valid & wb_dest == q_tag & q_tag != 0: ready = 1, value = wb_result (same-cycle bypass).
  - Else if entry busy & done: ready = 1, value = stored result.
  - Else ready = 0, value = 0.
  - Tag 0 always gives ready = 0.
- Reset takes priority over every other event, including one arriving mid-flush or mid-retire.

Decomposition:
- Shared package ysyx_rob_pkg holds:
  - rob_entry_t, the packed struct of per-entry fields;
  - tag_t, the TAG_W-wide tag type;
  - a tag-to-index conversion function.
- No sub-module: the storage array and the two identical query muxes stay inline.
- The query mux may be a function in the package.

Test Plan:
- Reset, then dispatch pc 0x8000_0000 with rd 5, pnpc 0x8000_0004 -> dis_tag 1. Writeback tag 1 with result 0x1234, npc 0x8000_0004 -> next cycle cm_valid = 1, cm_rd = 5, cm_result = 0x1234, flush_pipeline = 0.
- Dispatch tags 1, 2, 3. Write back 3, then 2, then 1 -> retires occur in order 1, 2, 3, one per cycle; cm_valid stays 0 until tag 1 completes.
- Dispatch ROB_SIZE = 8 entries -> dis_ready = 0. Retire tag 1 and dispatch on the same edge -> dispatch refused that cycle; dispatch is accepted the next cycle with dis_tag = 1 (wrap-around).
- Dispatch pnpc 0x100 but writeback npc 0x200 -> at retire flush_pipeline = 1 and flush_pc = 0x200. After the edge count = 0, dis_tag = 1, and the younger done entry is discarded.
- Writeback with wb_trap = 1, cause 2, npc 0x8000_0100 -> cm_trap = 1, cm_rd = 0, flush_pipeline = 1, flush_pc = 0x8000_0100.
- Query qa_tag = 2 while wb_valid with wb_dest = 2, result 0xAB -> qa_ready = 1 and qa_value = 0xAB in the same cycle. Assert reset mid-sequence -> all state cleared at the next edge.

Source files
------------

// File: rtl/ysyx_rob_pkg.sv
// ysyx_rob_pkg: shared sizing, types and helpers for the reorder buffer.
//   ROB_SIZE  number of entries (power of two, >= 2)
//   XLEN      datapath width
//   TAG_W     tag width; tag = entry index + 1, tag 0 = "no dependency"
//   rob_entry_t  payload stored per entry (busy/done flags live beside it)
//   query_t      result of an operand-value query
package ysyx_rob_pkg;

    localparam int ROB_SIZE = 8;
    localparam int XLEN     = 32;
    localparam int IDX_W    = $clog2(ROB_SIZE);
    localparam int TAG_W    = IDX_W + 1;

    typedef logic [TAG_W-1:0] tag_t;
    typedef logic [IDX_W-1:0] idx_t;

    localparam tag_t TAG_MAX = tag_t'(ROB_SIZE);

    typedef struct packed {
        logic [4:0]      rd;
        logic [XLEN-1:0] pc;
        logic [31:0]     inst;
        logic [XLEN-1:0] pnpc;
        logic [XLEN-1:0] result;
        logic [XLEN-1:0] npc;
        logic            trap;
        logic [XLEN-1:0] cause;
        logic [XLEN-1:0] tval;
    } rob_entry_t;

    typedef struct packed {
        logic            ready;
        logic [XLEN-1:0] value;
    } query_t;

    function automatic idx_t tag_to_idx(tag_t tag);
        tag_t dec;
        dec = tag - 1'b1;
        return dec[IDX_W-1:0];
    endfunction

    function automatic tag_t idx_to_tag(idx_t idx);
        return {1'b0, idx} + 1'b1;
    endfunction

    // Tags above ROB_SIZE would alias onto real entries after truncation.
    function automatic logic tag_valid(tag_t tag);
        return (tag != '0) && (tag <= TAG_MAX);
    endfunction

    // Same-cycle writeback bypass wins over the stored value.
    function automatic query_t rob_query(
        tag_t            q_tag,
        logic            wb_valid,
        tag_t            wb_dest,
        logic [XLEN-1:0] wb_result,
        logic            e_busy,
        logic            e_done,
        logic [XLEN-1:0] e_result
    );
        query_t r;
        r.ready = 1'b0;
        r.value = '0;
        if (wb_valid && (wb_dest == q_tag) && (q_tag != '0)) begin
            r.ready = 1'b1;
            r.value = wb_result;
        end else if (tag_valid(q_tag) && e_busy && e_done) begin
            r.ready = 1'b1;
            r.value = e_result;
        end
        return r;
    endfunction

endpackage

// File: rtl/ysyx_rob.sv
// ysyx_rob: reorder buffer between execute and retire.
//   dispatch  : dis_valid/dis_ready, dis_pc/inst/rd/pnpc in, dis_tag out
//   query A/B : qa_tag/qb_tag in, *_ready/*_value out (combinational)
//   writeback : wb_valid, wb_dest, wb_result, wb_npc, wb_trap/cause/tval
//   retire    : cm_valid, cm_tag, cm_rd, cm_result, cm_pc, cm_inst,
//               cm_trap/cause/tval (all zero when cm_valid = 0)
//   flush     : flush_pipeline, flush_pc
// Sizes come from ysyx_rob_pkg. Synchronous active-high reset.
module ysyx_rob
    import ysyx_rob_pkg::*;
(
    input  logic            clock,
    input  logic            reset,
    input  logic            dis_valid,
    output logic            dis_ready,
    input  logic [XLEN-1:0] dis_pc,
    input  logic [31:0]     dis_inst,
    input  logic [4:0]      dis_rd,
    input  logic [XLEN-1:0] dis_pnpc,
    output logic [TAG_W-1:0] dis_tag,
    input  logic [TAG_W-1:0] qa_tag,
    output logic            qa_ready,
    output logic [XLEN-1:0] qa_value,
    input  logic [TAG_W-1:0] qb_tag,
    output logic            qb_ready,
    output logic [XLEN-1:0] qb_value,
    input  logic            wb_valid,
    input  logic [TAG_W-1:0] wb_dest,
    input  logic [XLEN-1:0] wb_result,
    input  logic [XLEN-1:0] wb_npc,
    input  logic            wb_trap,
    input  logic [XLEN-1:0] wb_cause,
    input  logic [XLEN-1:0] wb_tval,
    output logic            cm_valid,
    output logic [TAG_W-1:0] cm_tag,
    output logic [4:0]      cm_rd,
    output logic [XLEN-1:0] cm_result,
    output logic [XLEN-1:0] cm_pc,
    output logic [31:0]     cm_inst,
    output logic            cm_trap,
    output logic [XLEN-1:0] cm_cause,
    output logic [XLEN-1:0] cm_tval,
    output logic            flush_pipeline,
    output logic [XLEN-1:0] flush_pc
);

    localparam logic [IDX_W:0] FULL_COUNT = (IDX_W+1)'(ROB_SIZE);

    // Flags kept outside the payload array so a flush clears them in one shot.
    logic [ROB_SIZE-1:0] busy;
    logic [ROB_SIZE-1:0] done;
    rob_entry_t          rob [ROB_SIZE];
    idx_t                head;
    idx_t                tail;
    logic [IDX_W:0]      count;

    idx_t       wb_idx;
    logic       wb_hit;
    logic       dis_fire;
    rob_entry_t hd;
    idx_t       qa_idx;
    idx_t       qb_idx;
    query_t     qa;
    query_t     qb;

    assign dis_ready = (count != FULL_COUNT);
    assign dis_tag   = idx_to_tag(tail);
    assign dis_fire  = dis_valid & dis_ready;

    assign wb_idx = tag_to_idx(wb_dest);
    assign wb_hit = wb_valid & tag_valid(wb_dest) & busy[wb_idx] & ~done[wb_idx];

    assign hd             = rob[head];
    assign cm_valid       = busy[head] & done[head];
    assign cm_tag         = cm_valid ? idx_to_tag(head) : '0;
    assign cm_trap        = cm_valid & hd.trap;
    assign cm_rd          = (cm_valid && !hd.trap) ? hd.rd : 5'd0;
    assign cm_result      = cm_valid ? hd.result : '0;
    assign cm_pc          = cm_valid ? hd.pc     : '0;
    assign cm_inst        = cm_valid ? hd.inst   : '0;
    assign cm_cause       = cm_valid ? hd.cause  : '0;
    assign cm_tval        = cm_valid ? hd.tval   : '0;
    assign flush_pipeline = cm_valid & (hd.trap | (hd.npc != hd.pnpc));
    assign flush_pc       = cm_valid ? hd.npc : '0;

    assign qa_idx   = tag_to_idx(qa_tag);
    assign qb_idx   = tag_to_idx(qb_tag);
    assign qa       = rob_query(qa_tag, wb_valid, wb_dest, wb_result,
                                busy[qa_idx], done[qa_idx], rob[qa_idx].result);
    assign qb       = rob_query(qb_tag, wb_valid, wb_dest, wb_result,
                                busy[qb_idx], done[qb_idx], rob[qb_idx].result);
    assign qa_ready = qa.ready;
    assign qa_value = qa.value;
    assign qb_ready = qb.ready;
    assign qb_value = qb.value;

    // Payload needs no reset: nothing reads it unless busy/done say so.
    // A dispatch slot is never busy and a writeback slot always is, so the
    // two writes never target the same entry.
    always_ff @(posedge clock) begin
        if (dis_fire) begin
            rob[tail].rd   <= dis_rd;
            rob[tail].pc   <= dis_pc;
            rob[tail].inst <= dis_inst;
            rob[tail].pnpc <= dis_pnpc;
        end
        if (wb_hit) begin
            rob[wb_idx].result <= wb_result;
            rob[wb_idx].npc    <= wb_npc;
            rob[wb_idx].trap   <= wb_trap;
            rob[wb_idx].cause  <= wb_cause;
            rob[wb_idx].tval   <= wb_tval;
        end
    end

    always_ff @(posedge clock) begin
        if (reset || flush_pipeline) begin
            busy  <= '0;
            done  <= '0;
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (wb_hit) begin
                done[wb_idx] <= 1'b1;
            end
            if (cm_valid) begin
                busy[head] <= 1'b0;
                done[head] <= 1'b0;
                head       <= head + 1'b1;
            end
            if (dis_fire) begin
                busy[tail] <= 1'b1;
                done[tail] <= 1'b0;
                tail       <= tail + 1'b1;
            end
            case ({dis_fire, cm_valid})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_rob.sv
module tb_ysyx_rob;

    logic        clock = 1'b0;
    logic        reset;
    logic        dis_valid;
    logic        dis_ready;
    logic [31:0] dis_pc;
    logic [31:0] dis_inst;
    logic [4:0]  dis_rd;
    logic [31:0] dis_pnpc;
    logic [3:0]  dis_tag;
    logic [3:0]  qa_tag;
    logic        qa_ready;
    logic [31:0] qa_value;
    logic [3:0]  qb_tag;
    logic        qb_ready;
    logic [31:0] qb_value;
    logic        wb_valid;
    logic [3:0]  wb_dest;
    logic [31:0] wb_result;
    logic [31:0] wb_npc;
    logic        wb_trap;
    logic [31:0] wb_cause;
    logic [31:0] wb_tval;
    logic        cm_valid;
    logic [3:0]  cm_tag;
    logic [4:0]  cm_rd;
    logic [31:0] cm_result;
    logic [31:0] cm_pc;
    logic [31:0] cm_inst;
    logic        cm_trap;
    logic [31:0] cm_cause;
    logic [31:0] cm_tval;
    logic        flush_pipeline;
    logic [31:0] flush_pc;

    int n_pass  = 0;
    int n_total = 0;

    ysyx_rob dut (
        .clock(clock), .reset(reset),
        .dis_valid(dis_valid), .dis_ready(dis_ready), .dis_pc(dis_pc),
        .dis_inst(dis_inst), .dis_rd(dis_rd), .dis_pnpc(dis_pnpc), .dis_tag(dis_tag),
        .qa_tag(qa_tag), .qa_ready(qa_ready), .qa_value(qa_value),
        .qb_tag(qb_tag), .qb_ready(qb_ready), .qb_value(qb_value),
        .wb_valid(wb_valid), .wb_dest(wb_dest), .wb_result(wb_result), .wb_npc(wb_npc),
        .wb_trap(wb_trap), .wb_cause(wb_cause), .wb_tval(wb_tval),
        .cm_valid(cm_valid), .cm_tag(cm_tag), .cm_rd(cm_rd), .cm_result(cm_result),
        .cm_pc(cm_pc), .cm_inst(cm_inst), .cm_trap(cm_trap), .cm_cause(cm_cause),
        .cm_tval(cm_tval), .flush_pipeline(flush_pipeline), .flush_pc(flush_pc)
    );

    always #5 clock = ~clock;

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish, got no end, expected end");
        $fatal(1, "timeout");
    end

    // Reference model: in-order list of live instructions, oldest first.
    typedef struct {
        int          tag;
        logic [4:0]  rd;
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] pnpc;
        bit          done;
        logic [31:0] result;
        logic [31:0] npc;
        bit          trap;
        logic [31:0] cause;
        logic [31:0] tval;
    } m_ent_t;

    m_ent_t m_q[$];
    int     m_next = 1;

    function automatic int m_find(int tag);
        for (int i = 0; i < m_q.size(); i++)
            if (m_q[i].tag == tag) return i;
        return -1;
    endfunction

    function automatic void m_query(input logic [3:0] t, output logic rdy, output logic [31:0] val);
        int i;
        rdy = 1'b0;
        val = 32'd0;
        if (wb_valid && wb_dest == t && t != 0) begin
            rdy = 1'b1;
            val = wb_result;
        end else begin
            i = m_find(int'(t));
            if (t != 0 && i >= 0 && m_q[i].done) begin
                rdy = 1'b1;
                val = m_q[i].result;
            end
        end
    endfunction

    // Applies one clock edge worth of events to the model using current inputs.
    task automatic m_edge();
        bit cmv, fl, full;
        int i;
        full = (m_q.size() == 8);
        cmv  = (m_q.size() > 0) && m_q[0].done;
        fl   = cmv && (m_q[0].trap || m_q[0].npc != m_q[0].pnpc);
        if (wb_valid && wb_dest != 0) begin
            i = m_find(int'(wb_dest));
            if (i >= 0 && !m_q[i].done) begin
                m_q[i].done   = 1;
                m_q[i].result = wb_result;
                m_q[i].npc    = wb_npc;
                m_q[i].trap   = wb_trap;
                m_q[i].cause  = wb_cause;
                m_q[i].tval   = wb_tval;
            end
        end
        if (cmv) void'(m_q.pop_front());
        if (fl) begin
            m_q.delete();
            m_next = 1;
        end else if (dis_valid && !full) begin
            m_ent_t e;
            e.tag = m_next; e.rd = dis_rd; e.pc = dis_pc; e.inst = dis_inst;
            e.pnpc = dis_pnpc; e.done = 0; e.result = 0; e.npc = 0;
            e.trap = 0; e.cause = 0; e.tval = 0;
            m_q.push_back(e);
            m_next = (m_next % 8) + 1;
        end
    endtask

    task automatic idle();
        dis_valid = 0; dis_pc = 0; dis_inst = 0; dis_rd = 0; dis_pnpc = 0;
        qa_tag = 0; qb_tag = 0;
        wb_valid = 0; wb_dest = 0; wb_result = 0; wb_npc = 0;
        wb_trap = 0; wb_cause = 0; wb_tval = 0;
    endtask

    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic do_reset();
        idle();
        reset = 1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 0;
        m_q.delete();
        m_next = 1;
    endtask

    task automatic dispatch(input logic [31:0] pc, input logic [4:0] rd, input logic [31:0] pnpc);
        dis_valid = 1; dis_pc = pc; dis_rd = rd; dis_pnpc = pnpc; dis_inst = pc ^ 32'h13;
        step();
        dis_valid = 0;
    endtask

    task automatic writeback(input logic [3:0] tag, input logic [31:0] res, input logic [31:0] npc,
                             input logic trap, input logic [31:0] cause, input logic [31:0] tval);
        wb_valid = 1; wb_dest = tag; wb_result = res; wb_npc = npc;
        wb_trap = trap; wb_cause = cause; wb_tval = tval;
        step();
        wb_valid = 0; wb_trap = 0;
    endtask

    task automatic test_reset();
        idle();
        reset = 1;
        dis_valid = 1; wb_valid = 1; wb_dest = 1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 0;
        idle();
        qa_tag = 1; qb_tag = 1;
        #1;
        n_total++; if (dis_ready !== 1'b1) $display("FAIL reset_dis_ready got %0d expected 1", dis_ready); else n_pass++;
        n_total++; if (dis_tag !== 4'd1) $display("FAIL reset_dis_tag got %0d expected 1", dis_tag); else n_pass++;
        n_total++; if (cm_valid !== 1'b0) $display("FAIL reset_cm_valid got %0d expected 0", cm_valid); else n_pass++;
        n_total++; if (flush_pipeline !== 1'b0) $display("FAIL reset_flush got %0d expected 0", flush_pipeline); else n_pass++;
        n_total++; if (qa_ready !== 1'b0 || qb_ready !== 1'b0) $display("FAIL reset_query got %0d%0d expected 00", qa_ready, qb_ready); else n_pass++;
        n_total++; if (cm_result !== 32'd0 || cm_pc !== 32'd0 || flush_pc !== 32'd0 || qa_value !== 32'd0)
            $display("FAIL reset_data got %h %h %h %h expected zeros", cm_result, cm_pc, flush_pc, qa_value); else n_pass++;
        m_q.delete();
        m_next = 1;
    endtask

    task automatic test_single();
        do_reset();
        #1;
        n_total++; if (dis_tag !== 4'd1) $display("FAIL single_tag got %0d expected 1", dis_tag); else n_pass++;
        dispatch(32'h8000_0000, 5'd5, 32'h8000_0004);
        #1;
        n_total++; if (cm_valid !== 1'b0) $display("FAIL single_early got %0d expected 0", cm_valid); else n_pass++;
        writeback(4'd1, 32'h1234, 32'h8000_0004, 1'b0, 32'd0, 32'd0);
        #1;
        n_total++; if (cm_valid !== 1'b1 || cm_tag !== 4'd1 || cm_rd !== 5'd5)
            $display("FAIL single_retire got v%0d t%0d rd%0d expected v1 t1 rd5", cm_valid, cm_tag, cm_rd); else n_pass++;
        n_total++; if (cm_result !== 32'h1234 || cm_pc !== 32'h8000_0000 || cm_inst !== (32'h8000_0000 ^ 32'h13))
            $display("FAIL single_data got %h %h %h expected 1234 80000000 80000013", cm_result, cm_pc, cm_inst); else n_pass++;
        n_total++; if (flush_pipeline !== 1'b0) $display("FAIL single_flush got %0d expected 0", flush_pipeline); else n_pass++;
        step();
        #1;
        n_total++; if (cm_valid !== 1'b0) $display("FAIL single_after got %0d expected 0", cm_valid); else n_pass++;
    endtask

    task automatic test_in_order();
        do_reset();
        for (int i = 1; i <= 3; i++) dispatch(32'(i * 4), 5'(i), 32'(i * 4 + 4));
        writeback(4'd3, 32'h33, 32'd16, 1'b0, 32'd0, 32'd0);
        #1;
        n_total++; if (cm_valid !== 1'b0) $display("FAIL order_wait3 got %0d expected 0", cm_valid); else n_pass++;
        writeback(4'd2, 32'h22, 32'd12, 1'b0, 32'd0, 32'd0);
        #1;
        n_total++; if (cm_valid !== 1'b0) $display("FAIL order_wait2 got %0d expected 0", cm_valid); else n_pass++;
        writeback(4'd1, 32'h11, 32'd8, 1'b0, 32'd0, 32'd0);
        for (int k = 1; k <= 3; k++) begin
            #1;
            n_total++; if (cm_valid !== 1'b1 || cm_tag !== 4'(k) || cm_result !== 32'(k * 17))
                $display("FAIL order_retire got v%0d t%0d r%h expected v1 t%0d r%h", cm_valid, cm_tag, cm_result, k, k * 17); else n_pass++;
            step();
        end
        #1;
        n_total++; if (cm_valid !== 1'b0) $display("FAIL order_empty got %0d expected 0", cm_valid); else n_pass++;
    endtask

    task automatic test_full_wrap();
        bit found = 0;
        do_reset();
        for (int i = 0; i < 8; i++) dispatch(32'(i * 4), 5'(i + 1), 32'(i * 4 + 4));
        #1;
        n_total++; if (dis_ready !== 1'b0) $display("FAIL full_ready got %0d expected 0", dis_ready); else n_pass++;
        writeback(4'd1, 32'h55, 32'd4, 1'b0, 32'd0, 32'd0);
        dis_valid = 1; dis_pc = 32'h900; dis_rd = 5'd9; dis_pnpc = 32'h904; dis_inst = 32'h900 ^ 32'h13;
        #1;
        n_total++; if (dis_ready !== 1'b0 || cm_valid !== 1'b1)
            $display("FAIL full_retire_cycle got r%0d v%0d expected r0 v1", dis_ready, cm_valid); else n_pass++;
        step();
        #1;
        n_total++; if (dis_ready !== 1'b1 || dis_tag !== 4'd1)
            $display("FAIL full_wrap_tag got r%0d t%0d expected r1 t1", dis_ready, dis_tag); else n_pass++;
        step();
        dis_valid = 0;
        #1;
        n_total++; if (dis_ready !== 1'b0 || dis_tag !== 4'd2)
            $display("FAIL full_again got r%0d t%0d expected r0 t2", dis_ready, dis_tag); else n_pass++;
        for (int t = 2; t <= 8; t++) writeback(4'(t), 32'(t), 32'((t - 1) * 4 + 4), 1'b0, 32'd0, 32'd0);
        writeback(4'd1, 32'h99, 32'h904, 1'b0, 32'd0, 32'd0);
        for (int k = 0; k < 20 && !found; k++) begin
            #1;
            if (cm_valid && cm_tag == 4'd1) found = 1;
            else step();
        end
        n_total++; if (!found || cm_pc !== 32'h900 || cm_result !== 32'h99)
            $display("FAIL wrap_retire got found%0d pc %h r %h expected found1 pc 900 r 99", found, cm_pc, cm_result); else n_pass++;
    endtask

    task automatic test_mispredict();
        do_reset();
        dispatch(32'h0FC, 5'd3, 32'h100);
        dispatch(32'h100, 5'd4, 32'h104);
        writeback(4'd2, 32'h2, 32'h104, 1'b0, 32'd0, 32'd0);
        writeback(4'd1, 32'h1, 32'h200, 1'b0, 32'd0, 32'd0);
        dis_valid = 1; dis_pc = 32'h300; dis_pnpc = 32'h304;
        #1;
        n_total++; if (cm_valid !== 1'b1 || flush_pipeline !== 1'b1 || flush_pc !== 32'h200)
            $display("FAIL mispredict_flush got v%0d f%0d pc %h expected v1 f1 pc 200", cm_valid, flush_pipeline, flush_pc); else n_pass++;
        step();
        dis_valid = 0;
        qa_tag = 4'd2;
        #1;
        n_total++; if (dis_tag !== 4'd1 || dis_ready !== 1'b1 || cm_valid !== 1'b0 || qa_ready !== 1'b0)
            $display("FAIL mispredict_after got t%0d r%0d v%0d q%0d expected t1 r1 v0 q0", dis_tag, dis_ready, cm_valid, qa_ready); else n_pass++;
        qa_tag = 0;
    endtask

    task automatic test_trap();
        do_reset();
        dispatch(32'h8000_0040, 5'd7, 32'h8000_0044);
        writeback(4'd1, 32'h77, 32'h8000_0100, 1'b1, 32'd2, 32'hDEAD);
        #1;
        n_total++; if (cm_valid !== 1'b1 || cm_trap !== 1'b1 || cm_rd !== 5'd0)
            $display("FAIL trap_retire got v%0d trap%0d rd%0d expected v1 trap1 rd0", cm_valid, cm_trap, cm_rd); else n_pass++;
        n_total++; if (cm_cause !== 32'd2 || cm_tval !== 32'hDEAD)
            $display("FAIL trap_info got %h %h expected 2 dead", cm_cause, cm_tval); else n_pass++;
        n_total++; if (flush_pipeline !== 1'b1 || flush_pc !== 32'h8000_0100)
            $display("FAIL trap_flush got f%0d pc %h expected f1 pc 80000100", flush_pipeline, flush_pc); else n_pass++;
        step();
        #1;
        n_total++; if (cm_valid !== 1'b0 || dis_tag !== 4'd1)
            $display("FAIL trap_after got v%0d t%0d expected v0 t1", cm_valid, dis_tag); else n_pass++;
    endtask

    task automatic test_query_bypass();
        do_reset();
        dispatch(32'h10, 5'd1, 32'h14);
        dispatch(32'h14, 5'd2, 32'h18);
        wb_valid = 1; wb_dest = 4'd2; wb_result = 32'hAB; wb_npc = 32'h18;
        qa_tag = 4'd2; qb_tag = 4'd1;
        #1;
        n_total++; if (qa_ready !== 1'b1 || qa_value !== 32'hAB)
            $display("FAIL query_bypass got r%0d v%h expected r1 vab", qa_ready, qa_value); else n_pass++;
        n_total++; if (qb_ready !== 1'b0 || qb_value !== 32'd0)
            $display("FAIL query_pending got r%0d v%h expected r0 v0", qb_ready, qb_value); else n_pass++;
        step();
        wb_valid = 1; wb_dest = 4'd0; wb_result = 32'h5A; qb_tag = 4'd0;
        #1;
        n_total++; if (qa_ready !== 1'b1 || qa_value !== 32'hAB)
            $display("FAIL query_stored got r%0d v%h expected r1 vab", qa_ready, qa_value); else n_pass++;
        n_total++; if (qb_ready !== 1'b0)
            $display("FAIL query_tag0 got r%0d expected r0", qb_ready); else n_pass++;
        idle();
    endtask

    task automatic test_reset_mid();
        do_reset();
        dispatch(32'h20, 5'd1, 32'h24);
        dispatch(32'h24, 5'd2, 32'h28);
        writeback(4'd1, 32'h1, 32'h400, 1'b0, 32'd0, 32'd0);
        reset = 1;
        dis_valid = 1; dis_pc = 32'h500; dis_pnpc = 32'h504;
        wb_valid = 1; wb_dest = 4'd2; wb_result = 32'h2; wb_npc = 32'h28;
        step();
        reset = 0;
        idle();
        qa_tag = 4'd2;
        #1;
        n_total++; if (dis_tag !== 4'd1 || dis_ready !== 1'b1 || cm_valid !== 1'b0 || flush_pipeline !== 1'b0 || qa_ready !== 1'b0)
            $display("FAIL reset_mid got t%0d r%0d v%0d f%0d q%0d expected t1 r1 v0 f0 q0",
                     dis_tag, dis_ready, cm_valid, flush_pipeline, qa_ready); else n_pass++;
        idle();
    endtask

    task automatic test_random();
        int   pend[$];
        int   idx;
        int   r;
        logic e_ready;
        logic e_cmv, e_flush;
        logic ea_r, eb_r;
        logic [31:0] ea_v, eb_v;
        do_reset();
        for (int cyc = 0; cyc < 800; cyc++) begin
            dis_valid = ($urandom_range(0, 3) != 0);
            dis_pc    = $urandom;
            dis_inst  = $urandom;
            dis_rd    = 5'($urandom_range(0, 31));
            dis_pnpc  = dis_pc + 32'd4;
            wb_valid  = 0; wb_dest = 0; wb_trap = 0;
            pend.delete();
            for (int i = 0; i < m_q.size(); i++) if (!m_q[i].done) pend.push_back(i);
            if ($urandom_range(0, 3) != 0) begin
                wb_valid = 1;
                if (pend.size() > 0 && $urandom_range(0, 7) != 0)
                    wb_dest = 4'(m_q[pend[$urandom_range(0, pend.size() - 1)]].tag);
                else
                    wb_dest = 4'($urandom_range(0, 8));
                wb_result = $urandom;
                wb_cause  = $urandom;
                wb_tval   = $urandom;
                idx = m_find(int'(wb_dest));
                r = $urandom_range(0, 39);
                wb_trap = (r == 0);
                wb_npc  = (idx >= 0 && r != 1) ? m_q[idx].pnpc : $urandom;
            end
            qa_tag = ($urandom_range(0, 1) != 0) ? wb_dest : 4'($urandom_range(0, 8));
            qb_tag = 4'($urandom_range(0, 8));

            e_ready = (m_q.size() != 8);
            e_cmv   = (m_q.size() > 0) && m_q[0].done;
            e_flush = e_cmv && (m_q[0].trap || m_q[0].npc != m_q[0].pnpc);
            m_query(qa_tag, ea_r, ea_v);
            m_query(qb_tag, eb_r, eb_v);
            #1;
            n_total++; if (dis_ready !== e_ready || dis_tag !== 4'(m_next))
                $display("FAIL rnd_dispatch c%0d got r%0d t%0d expected r%0d t%0d", cyc, dis_ready, dis_tag, e_ready, m_next); else n_pass++;
            n_total++; if (cm_valid !== e_cmv || flush_pipeline !== e_flush)
                $display("FAIL rnd_retire c%0d got v%0d f%0d expected v%0d f%0d", cyc, cm_valid, flush_pipeline, e_cmv, e_flush); else n_pass++;
            if (e_cmv) begin
                n_total++; if (cm_tag !== 4'(m_q[0].tag) || cm_pc !== m_q[0].pc || cm_inst !== m_q[0].inst ||
                               cm_result !== m_q[0].result || cm_trap !== m_q[0].trap ||
                               cm_rd !== (m_q[0].trap ? 5'd0 : m_q[0].rd) || flush_pc !== m_q[0].npc)
                    $display("FAIL rnd_cm c%0d got t%0d pc %h r %h rd %0d fpc %h expected t%0d pc %h r %h rd %0d fpc %h",
                             cyc, cm_tag, cm_pc, cm_result, cm_rd, flush_pc, m_q[0].tag, m_q[0].pc,
                             m_q[0].result, m_q[0].trap ? 5'd0 : m_q[0].rd, m_q[0].npc); else n_pass++;
            end
            n_total++; if (qa_ready !== ea_r || qa_value !== ea_v || qb_ready !== eb_r || qb_value !== eb_v)
                $display("FAIL rnd_query c%0d got a%0d %h b%0d %h expected a%0d %h b%0d %h",
                         cyc, qa_ready, qa_value, qb_ready, qb_value, ea_r, ea_v, eb_r, eb_v); else n_pass++;
            @(posedge clock);
            m_edge();
            @(negedge clock);
        end
        idle();
    endtask

    initial begin
        idle();
        reset = 1;
        @(negedge clock);
        test_reset();
        test_single();
        test_in_order();
        test_full_wrap();
        test_mispredict();
        test_trap();
        test_query_bypass();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
